// File: rtl/rightshift.sv
// rightshift: sequential 32-bit logical/arithmetic right shifter.
// Shifts one bit position per clock. A request on ctrl is accepted only
// while idle; the result appears on out with a one-cycle out_en pulse.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   a      in   [31:0] operand
//   b      in   [4:0]  shift amount
//   ctrl   in   [4:0]  opcode (SRL_OP / SRA_OP start an operation)
//   busy   out  high while shifting (decoded from state)
//   out_en out  one-cycle pulse when out is updated
//   out    out  [31:0] registered result
module rightshift #(
  parameter logic [4:0] SRL_OP = 5'd1,
  parameter logic [4:0] SRA_OP = 5'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic [4:0]  ctrl,
  output logic        busy,
  output logic        out_en,
  output logic [31:0] out
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            arith_q, arith_d;
  logic [DW-1:0]   out_q, out_d;
  logic            out_en_q, out_en_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      arith_q  <= 1'b0;
      out_q    <= '0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      arith_q  <= arith_d;
      out_q    <= out_d;
      out_en_q <= out_en_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    arith_d  = arith_q;
    out_d    = out_q;
    out_en_d = 1'b0;

    case (state_q)
      IDLE: begin
        if ((ctrl == SRL_OP) || (ctrl == SRA_OP)) begin
          shreg_d = a;
          cnt_d   = b;
          arith_d = (ctrl == SRA_OP);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          // Sign bit is replicated only for arithmetic shifts
          shreg_d = {shreg_q[DW-1] & arith_q, shreg_q[DW-1:1]};
          cnt_d   = cnt_q - SW'(1);
        end else begin
          out_d    = shreg_q;
          out_en_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == SHIFT);
  assign out_en = out_en_q;
  assign out    = out_q;

endmodule
